// File: rtl/microwave_pkg.sv
// microwave_pkg: shared types and constants for the microwave controller timer.
package microwave_pkg;

  localparam int unsigned DIGIT_W = 4;

  // Controller states
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SET     = 3'd1,
    ST_RUNNING = 3'd2,
    ST_PAUSED  = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  // Digit code the downstream 7-segment decoder renders as all segments off
  localparam logic [DIGIT_W-1:0] BLANK_DIGIT   = 4'hF;
  // Value a BCD field takes after borrowing: seconds tens wrap to 5, ones to 9
  localparam logic [DIGIT_W-1:0] SEC_WRAP_TENS = 4'd5;
  localparam logic [DIGIT_W-1:0] SEC_WRAP_ONES = 4'd9;

  // Four BCD digits of an MM:SS value, most significant first
  typedef struct packed {
    logic [DIGIT_W-1:0] min_tens;
    logic [DIGIT_W-1:0] min_ones;
    logic [DIGIT_W-1:0] sec_tens;
    logic [DIGIT_W-1:0] sec_ones;
  } mmss_t;

endpackage

// File: rtl/bcd_mmss_dec.sv
// bcd_mmss_dec: combinational one-second decrement of a BCD MM:SS value.
// A seconds field of 60..99 simply counts down; 00:00 stays at 00:00.
module bcd_mmss_dec
  import microwave_pkg::*;
(
  input  mmss_t i_mmss,
  output mmss_t o_mmss,
  output logic  o_zero
);

  mmss_t w_res;

  // Borrow chain: sec_ones -> sec_tens -> min_ones -> min_tens
  always_comb begin
    w_res = i_mmss;
    if (i_mmss.sec_ones != '0) begin
      w_res.sec_ones = i_mmss.sec_ones - 4'd1;
    end else if (i_mmss.sec_tens != '0) begin
      w_res.sec_tens = i_mmss.sec_tens - 4'd1;
      w_res.sec_ones = SEC_WRAP_ONES;
    end else if (i_mmss.min_ones != '0) begin
      w_res.min_ones = i_mmss.min_ones - 4'd1;
      w_res.sec_tens = SEC_WRAP_TENS;
      w_res.sec_ones = SEC_WRAP_ONES;
    end else if (i_mmss.min_tens != '0) begin
      w_res.min_tens = i_mmss.min_tens - 4'd1;
      w_res.min_ones = SEC_WRAP_ONES;
      w_res.sec_tens = SEC_WRAP_TENS;
      w_res.sec_ones = SEC_WRAP_ONES;
    end
  end

  assign o_mmss = w_res;
  assign o_zero = (w_res == '0);

endmodule

// File: rtl/countdown_timer.sv
// countdown_timer: keypad-entered MM:SS cooking timer counting down at 1 Hz.
// Optional build macro PAUSE_BLINK_EN: digits blink (value / blank) in PAUSED
// and DONE every CLK_HZ/4 cycles; without it the digits are always shown.
module countdown_timer
  import microwave_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 50_000_000,
  parameter int unsigned QUICK_SEC = 30
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [DIGIT_W-1:0] digit_in,
  input  logic               digit_valid,
  input  logic               start,
  input  logic               pause,
  input  logic               clear,
  input  logic               door_open,
  output logic [DIGIT_W-1:0] min_tens,
  output logic [DIGIT_W-1:0] min_ones,
  output logic [DIGIT_W-1:0] sec_tens,
  output logic [DIGIT_W-1:0] sec_ones,
  output logic               running,
  output logic               done
);

  localparam int unsigned       PRESC_W    = $clog2(CLK_HZ);
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_HZ - 1);
  localparam mmss_t QUICK_VAL = mmss_t'({8'h00, 4'(QUICK_SEC / 10), 4'(QUICK_SEC % 10)});

  state_e             r_state, w_state_nxt;
  mmss_t              r_digits, w_digits_nxt;
  mmss_t              w_dec, w_shift;
  logic [PRESC_W-1:0] r_presc, w_presc_nxt;
  logic               r_running, r_done, w_done_nxt;
  logic               w_tick, w_dec_zero, w_start_ok, w_digit_ok;

  assign w_tick     = (r_presc == PRESC_LAST);
  assign w_start_ok = start & ~door_open;
  assign w_digit_ok = digit_valid & (digit_in <= 4'd9);
  // A new entry after completion starts from 0000 instead of the finished value
  assign w_shift    = (r_state == ST_DONE) ? mmss_t'({12'h000, digit_in})
                                           : mmss_t'({r_digits[11:0], digit_in});

  bcd_mmss_dec u_dec (
    .i_mmss (r_digits),
    .o_mmss (w_dec),
    .o_zero (w_dec_zero)
  );

  // Next state, digit value, prescaler and completion pulse
  always_comb begin
    w_state_nxt  = r_state;
    w_digits_nxt = r_digits;
    w_presc_nxt  = '0;
    w_done_nxt   = 1'b0;
    if (clear) begin
      w_state_nxt  = ST_IDLE;
      w_digits_nxt = '0;
    end else begin
      case (r_state)
        ST_RUNNING: begin
          if (pause || door_open) begin
            w_state_nxt = ST_PAUSED;
          end else if (w_tick) begin
            w_digits_nxt = w_dec;
            if (w_dec_zero) begin
              w_state_nxt = ST_DONE;
              w_done_nxt  = 1'b1;
            end
          end else begin
            w_presc_nxt = r_presc + PRESC_W'(1);
          end
        end
        ST_PAUSED: begin
          if (w_start_ok) w_state_nxt = ST_RUNNING;
        end
        ST_IDLE, ST_DONE: begin
          if (w_start_ok) begin
            w_digits_nxt = QUICK_VAL;
            w_state_nxt  = ST_RUNNING;
          end else if (w_digit_ok) begin
            w_digits_nxt = w_shift;
            w_state_nxt  = ST_SET;
          end
        end
        ST_SET: begin
          if (w_start_ok) begin
            w_state_nxt = (r_digits != '0) ? ST_RUNNING : ST_IDLE;
          end else if (w_digit_ok) begin
            w_digits_nxt = w_shift;
          end
        end
        default: begin
          w_state_nxt  = ST_IDLE;
          w_digits_nxt = '0;
        end
      endcase
    end
  end

  // State, digits, prescaler and status outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_digits  <= '0;
      r_presc   <= '0;
      r_running <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_digits  <= w_digits_nxt;
      r_presc   <= w_presc_nxt;
      r_running <= (w_state_nxt == ST_RUNNING);
      r_done    <= w_done_nxt;
    end
  end

  assign running = r_running;
  assign done    = r_done;

`ifdef PAUSE_BLINK_EN
  localparam int unsigned        BLINK_CYC  = CLK_HZ / 4;
  localparam int unsigned        BLINK_W    = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYC - 1);

  logic [BLINK_W-1:0] r_blink_cnt, w_blink_cnt_nxt;
  logic               r_blank, w_blank_nxt, w_blink_state;
  mmss_t              r_disp, w_disp_nxt;

  assign w_blink_state = (w_state_nxt == ST_PAUSED) || (w_state_nxt == ST_DONE);

  // Blink phase restarts visible on entry to PAUSED/DONE; digit registers untouched
  always_comb begin
    w_blink_cnt_nxt = '0;
    w_blank_nxt     = 1'b0;
    if (w_blink_state && (w_state_nxt == r_state)) begin
      if (r_blink_cnt == BLINK_LAST) begin
        w_blank_nxt = ~r_blank;
      end else begin
        w_blink_cnt_nxt = r_blink_cnt + BLINK_W'(1);
        w_blank_nxt     = r_blank;
      end
    end
    w_disp_nxt = w_blank_nxt ? mmss_t'({4{BLANK_DIGIT}}) : w_digits_nxt;
  end

  // Blink counter and registered display digits
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_blink_cnt <= '0;
      r_blank     <= 1'b0;
      r_disp      <= '0;
    end else begin
      r_blink_cnt <= w_blink_cnt_nxt;
      r_blank     <= w_blank_nxt;
      r_disp      <= w_disp_nxt;
    end
  end

  assign min_tens = r_disp.min_tens;
  assign min_ones = r_disp.min_ones;
  assign sec_tens = r_disp.sec_tens;
  assign sec_ones = r_disp.sec_ones;
`else
  assign min_tens = r_digits.min_tens;
  assign min_ones = r_digits.min_ones;
  assign sec_tens = r_digits.sec_tens;
  assign sec_ones = r_digits.sec_ones;
`endif

endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: directed scenarios plus random stimulus, checked each
// cycle against an integer-arithmetic model of the timer.
module tb_countdown_timer;

  localparam int HZ = 4;
  localparam int QS = 30;

  localparam int M_IDLE   = 0;
  localparam int M_SET    = 1;
  localparam int M_RUN    = 2;
  localparam int M_PAUSED = 3;
  localparam int M_DONE   = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] digit_in = 4'd0;
  logic       digit_valid = 1'b0;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       clear = 1'b0;
  logic       door_open = 1'b0;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic       running, done;
  logic [15:0] disp;

  int n_checks = 0;
  int n_errors = 0;

  // Model: time kept as plain integers minutes/seconds
  typedef struct packed {
    int   st;
    int   mn;
    int   sc;
    int   cnt;
    logic dn;
  } mstate_t;

  mstate_t m;

  countdown_timer #(.CLK_HZ(HZ), .QUICK_SEC(QS)) dut (
    .clk         (clk),
    .reset       (reset),
    .digit_in    (digit_in),
    .digit_valid (digit_valid),
    .start       (start),
    .pause       (pause),
    .clear       (clear),
    .door_open   (door_open),
    .min_tens    (min_tens),
    .min_ones    (min_ones),
    .sec_tens    (sec_tens),
    .sec_ones    (sec_ones),
    .running     (running),
    .done        (done)
  );

  assign disp = {min_tens, min_ones, sec_tens, sec_ones};

  always #5 clk = ~clk;

  function automatic mstate_t model_next(input mstate_t cur, input logic i_clr,
                                         input logic i_pause, input logic i_start,
                                         input logic i_door, input logic i_dv,
                                         input logic [3:0] i_d);
    mstate_t n;
    int v;
    n = cur;
    n.dn = 1'b0;
    if (i_clr) begin
      n.st = M_IDLE; n.mn = 0; n.sc = 0;
    end else if (cur.st == M_RUN) begin
      if (i_pause || i_door) begin
        n.st = M_PAUSED;
      end else begin
        n.cnt = cur.cnt + 1;
        if (n.cnt == HZ) begin
          n.cnt = 0;
          if (n.sc > 0) n.sc = n.sc - 1;
          else begin n.mn = n.mn - 1; n.sc = 59; end
          if (n.mn == 0 && n.sc == 0) begin n.st = M_DONE; n.dn = 1'b1; end
        end
      end
    end else if (cur.st == M_PAUSED) begin
      if (i_start && !i_door) begin n.st = M_RUN; n.cnt = 0; end
    end else if (i_start && !i_door) begin
      if (cur.st == M_SET && cur.mn == 0 && cur.sc == 0) begin
        n.st = M_IDLE;
      end else begin
        if (cur.st != M_SET) begin n.mn = 0; n.sc = QS; end
        n.st = M_RUN; n.cnt = 0;
      end
    end else if (i_dv && i_d <= 4'd9) begin
      v = (cur.st == M_DONE) ? 0 : cur.mn * 100 + cur.sc;
      v = (v * 10 + int'(i_d)) % 10000;
      n.mn = v / 100; n.sc = v % 100; n.st = M_SET;
    end
    return n;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) m <= '0;
    else       m <= model_next(m, clear, pause, start, door_open, digit_valid, digit_in);
  end

  function automatic logic [15:0] exp_disp(input int mn, input int sc);
    return {4'(mn / 10), 4'(mn % 10), 4'(sc / 10), 4'(sc % 10)};
  endfunction

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, got, exp);
    end
  endtask

  // Every cycle: advance to the falling edge and compare the DUT with the model
  task automatic tick_cycle();
    @(negedge clk);
    if (!reset) begin
      check("model_digits", disp, exp_disp(m.mn, m.sc));
      check("model_running", 16'(running), 16'(m.st == M_RUN));
      check("model_done", 16'(done), 16'(m.dn));
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) tick_cycle();
  endtask

  task automatic press_digit(input logic [3:0] d);
    digit_in = d; digit_valid = 1'b1;
    tick_cycle();
    digit_valid = 1'b0;
  endtask

  task automatic press_start();
    start = 1'b1; tick_cycle(); start = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1; tick_cycle(); clear = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("reset_digits", disp, 16'h0000);
    check("reset_running", 16'(running), 16'h0);
    check("reset_done", 16'(done), 16'h0);
    tick_cycle();

    // Entry 1,3,0 then start; first decrement 4 cycles after running rises
    press_digit(4'd1); press_digit(4'd3); press_digit(4'd0);
    check("entry_digits", disp, 16'h0130);
    press_start();
    check("entry_running", 16'(running), 16'h1);
    wait_cycles(3);
    check("entry_hold", disp, 16'h0130);
    tick_cycle();
    check("entry_first_dec", disp, 16'h0129);
    check("model_pin_0129", exp_disp(m.mn, m.sc), 16'h0129);
    do_clear();

    // Borrow across minutes
    press_digit(4'd1); press_digit(4'd0); press_digit(4'd0);
    press_start(); wait_cycles(4);
    check("borrow_0059", disp, 16'h0059);
    do_clear();
    press_digit(4'd1); press_digit(4'd0); press_digit(4'd0); press_digit(4'd0);
    press_start(); wait_cycles(4);
    check("borrow_0959", disp, 16'h0959);
    do_clear();

    // Completion from 00:02
    press_digit(4'd2); press_start(); wait_cycles(4);
    check("complete_0001", disp, 16'h0001);
    wait_cycles(3);
    check("complete_pre_running", 16'(running), 16'h1);
    check("complete_pre_done", 16'(done), 16'h0);
    tick_cycle();
    check("complete_0000", disp, 16'h0000);
    check("complete_done", 16'(done), 16'h1);
    check("complete_running", 16'(running), 16'h0);
    check("model_pin_done_state", 16'(m.st), 16'(M_DONE));
    tick_cycle();
    check("complete_done_single", 16'(done), 16'h0);
    wait_cycles(5);

    // Quick start, and start ignored with door open
    do_clear(); press_start();
    check("quick_digits", disp, 16'h0030);
    check("quick_running", 16'(running), 16'h1);
    do_clear();
    door_open = 1'b1; press_start();
    check("door_start_digits", disp, 16'h0000);
    check("door_start_running", 16'(running), 16'h0);
    door_open = 1'b0;

    // Door opened at 00:45 holds, resume restarts the tick phase
    press_digit(4'd4); press_digit(4'd5); press_start();
    door_open = 1'b1; wait_cycles(20);
    check("pause_hold_digits", disp, 16'h0045);
    check("pause_hold_running", 16'(running), 16'h0);
    door_open = 1'b0; press_start();
    check("resume_running", 16'(running), 16'h1);
    wait_cycles(3);
    check("resume_hold", disp, 16'h0045);
    tick_cycle();
    check("resume_dec", disp, 16'h0044);
    do_clear();

    // Tick and pause in the same cycle: pause wins
    press_start(); wait_cycles(3);
    pause = 1'b1; tick_cycle(); pause = 1'b0;
    check("tick_pause_digits", disp, 16'h0030);
    check("tick_pause_running", 16'(running), 16'h0);
    do_clear();

    // Final tick and clear together: no done pulse
    press_digit(4'd1); press_start(); wait_cycles(3);
    clear = 1'b1; tick_cycle(); clear = 1'b0;
    check("final_clear_digits", disp, 16'h0000);
    check("final_clear_done", 16'(done), 16'h0);

    // clear beats pause and start
    press_start();
    clear = 1'b1; pause = 1'b1; start = 1'b1;
    tick_cycle();
    clear = 1'b0; pause = 1'b0; start = 1'b0;
    check("prio_digits", disp, 16'h0000);
    check("prio_running", 16'(running), 16'h0);

    // Invalid digit ignored
    press_digit(4'hA);
    check("invalid_idle", disp, 16'h0000);
    press_digit(4'd5); press_digit(4'hA);
    check("invalid_set", disp, 16'h0005);
    do_clear();

    // Asynchronous reset between edges
    press_start(); wait_cycles(6);
    #2 reset = 1'b1;
    #1;
    check("async_reset_digits", disp, 16'h0000);
    check("async_reset_running", 16'(running), 16'h0);
    @(negedge clk);
    reset = 1'b0;
    wait_cycles(2);

    // Random stimulus against the model
    for (int i = 0; i < 4000; i++) begin
      clear       = ($urandom_range(0, 149) == 0);
      pause       = ($urandom_range(0, 39) == 0);
      start       = ($urandom_range(0, 11) == 0);
      digit_valid = ($urandom_range(0, 3) == 0);
      digit_in    = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 29) == 0) door_open = ~door_open;
      tick_cycle();
    end
    clear = 1'b0; pause = 1'b0; start = 1'b0; digit_valid = 1'b0; door_open = 1'b0;
    tick_cycle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
# countdown_timer

Cooking-time countdown for the microwave controller. Accepts BCD keypad digits, holds an MM:SS setting, counts it down at 1 Hz while running, and drives four 4-bit BCD digit buses. Each bus feeds one instance of the 7-segment BCD display decoder directly downstream. Codes above 9 on a digit bus are the agreed "blank" code, which the decoder renders with all segments off.

## Interface
Parameters:
- CLK_HZ, 50_000_000, clock cycles per 1-second tick; minimum 4.
- QUICK_SEC, 30, seconds loaded by quick start; 1..59.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- digit_in  in  4  keypad digit, BCD 0..9
- digit_valid  in  1  one-cycle strobe qualifying digit_in
- start  in  1  start/resume strobe
- pause  in  1  pause strobe
- clear  in  1  cancel/clear strobe
- door_open  in  1  level, 1 = door open
- min_tens, min_ones, sec_tens, sec_ones  out  4 each  BCD digits to the decoders
- running  out  1  high in RUNNING; enables the magnetron
- done  out  1  one-cycle pulse on countdown completion

## Operation
- States: IDLE, SET, RUNNING, PAUSED, DONE.
- Reset:
  - state IDLE, all digits 0, running 0, done 0, prescaler 0.
- Input priority in any cycle: clear > door_open/pause > start > digit_valid.
- clear, from any state:
  - go to IDLE, digits to 0000.
- digit_valid in IDLE, SET or DONE with digit_in ≤ 9:
  - shift left: min_tens←min_ones, min_ones←sec_tens, sec_tens←sec_ones, sec_ones←digit_in.
  - go to SET.
  - In DONE, the shift starts from 0000.
- digit_valid with digit_in > 9: ignored. digit_valid in RUNNING/PAUSED: ignored.
- start in IDLE or DONE with door closed:
  - load 00:QUICK_SEC, go to RUNNING.
- start in SET with door closed:
  - value nonzero: go to RUNNING.
  - value 0000: go to IDLE.
- start in PAUSED with door closed: go to RUNNING.
- start while door_open: ignored.
- Seconds field may hold 60..99 (e.g. 01:90). It counts down without normalisation.
- pause or door_open in RUNNING: go to PAUSED, digits hold.
- Decrement rule, applied once per tick in RUNNING, all BCD:
  - sec_ones>0: sec_ones−1.
  - else sec_tens>0: sec_tens−1, sec_ones←9.
  - else borrow from minutes, seconds←59.
  - Minutes decrement in BCD the same way.
- Reaching 00:00: state DONE, done pulses, running drops.

## Timing
- All outputs are registered.
- Prescaler:
  - Runs only in RUNNING; counts 0..CLK_HZ−1.
  - Cleared on every entry to RUNNING, so the tick phase is not preserved across a pause.
  - The tick occurs in the cycle the prescaler equals CLK_HZ−1.
  - The first decrement is visible CLK_HZ cycles after the cycle in which running first reads 1.
- Strobes are sampled at the clk edge; the state change is visible the next cycle.
- running rises one cycle after the accepted start.
- The final decrement to 00:00, the transition to DONE, the done high and the running low all appear on the same edge.
- done is high for exactly one cycle.
- Simultaneous events:
  - Tick and pause in the same cycle: pause wins, no decrement.
  - Final tick and clear in the same cycle: clear wins, done does not pulse.
- reset mid-count: immediate IDLE/0000, regardless of clk.

## Configuration
- Macro PAUSE_BLINK_EN.
- Defined:
  - In PAUSED and DONE, all four digit outputs alternate between their values and 4'hF (blank) every CLK_HZ/4 cycles.
  - The blink counter is cleared on state entry, and the digits start visible.
  - Internal digit registers are unaffected.
- Undefined: digits are always shown, and there is no blink counter logic.

## Structure
- Shared package microwave_pkg holds:
  - the state enum,
  - BLANK_DIGIT = 4'hF,
  - the SEC_WRAP_TENS = 5 and SEC_WRAP_ONES = 9 constants.
- Sub-module bcd_mmss_dec: combinational MM:SS BCD decrement, 16 bits in, 16 bits out, plus a zero flag. It is instantiated once.

## Test plan
All scenarios use CLK_HZ=4.
- Entry: digits 1,3,0 then start → outputs 0,1,3,0. First decrement to 01:29 appears 4 cycles after running rises.
- Borrow: 01:00 running → next tick shows 00:59; 10:00 → 09:59.
- Completion: 00:02 → 00:01 → 00:00. done pulses exactly once, running drops, state DONE.
- Quick start: start in IDLE → 00:30, running=1. start with door_open=1 → no change.
- Pause/resume: door_open during RUNNING at 00:45 → digits hold 00:45 across 20 cycles. Door closed + start → resumes, next decrement after 4 cycles.
- Priority/reset:
  - clear with pause and start in the same cycle → IDLE 0000.
  - reset asserted mid-count between clk edges → outputs 0000 immediately.
  - Invalid digit 4'hA → ignored.
